bank_queue_monitor: RTL and testbench

- Single-bank queue manager: tracks the number of customers in line from two photo-sensor inputs (entry at back, exit at front).
- Reports estimated wait time from a combinational lookup indexed by count and active tellers, plus full/empty flags.
- Sits between the sensor front-end and the display/driver logic.

---
 rtl/bank_queue_pkg.sv | 28 ++
 rtl/wait_time_rom.sv | 48 ++++
 rtl/bank_queue_monitor.sv | 103 ++++++++++
 tb/tb_bank_queue_monitor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bank_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bank_queue_pkg
//  Description : Shared constants for the single-bank queue monitor: default
//                count width, teller limit, per-customer service time and the
//                wait-time output width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bank_queue_pkg;

    // Default width of the person count (capacity = 2**N-1 customers)
    localparam int N_DEFAULT    = 3;

    // Highest number of tellers that can be active at once
    localparam int TELLER_MAX   = 3;

    // Minutes of service per customer used in the wait-time estimate
    localparam int SERVICE_TIME = 3;

    // Width of the wait-time output for a given count width.
    // The largest estimate is 3*(2**N-1) with a single teller, which is
    // always below 2**(N+2).
    function automatic int wtime_width(input int n);
        return n + 2;
    endfunction

endpackage : bank_queue_pkg
`default_nettype wire

// File: rtl/wait_time_rom.sv
`default_nettype none
// ============================================================================
//  Module      : wait_time_rom
//  Description : Purely combinational wait-time lookup.
//                Wtime = floor(SERVICE_TIME*(Pcount+Tcount-1)/Tcount),
//                forced to 0 when the queue is empty or no teller is active.
//  Ports       : Pcount  in  [N-1:0]  current customers in line
//                Tcount  in  [1:0]    active tellers (0 = invalid)
//                Wtime   out [N+1:0]  estimated wait time
//  Revision    : 1.0 - initial release
// ============================================================================
module wait_time_rom
    import bank_queue_pkg::*;
#(
    parameter int N = N_DEFAULT
)
(
    input  logic [N-1:0] Pcount,
    input  logic [1:0]   Tcount,
    output logic [N+1:0] Wtime
);

    localparam int WTW = wtime_width(N);
    // Intermediate width wide enough for SERVICE_TIME*(2**N-1+TELLER_MAX-1)
    localparam int SW  = N + 4;

    logic [SW-1:0] sum;
    logic [SW-1:0] num;
    logic [SW-1:0] quo;

    always_comb begin
        sum = SW'(Pcount) + SW'(Tcount) - SW'(1);
        num = sum * SW'(SERVICE_TIME);
        quo = '0;
        if (Pcount != '0) begin
            // Divisors are constants per branch, so no general divider is built
            case (Tcount)
                2'd1:    quo = num;
                2'd2:    quo = num / SW'(2);
                2'd3:    quo = num / SW'(3);
                default: quo = '0;
            endcase
        end
        Wtime = WTW'(quo);
    end

endmodule : wait_time_rom
`default_nettype wire

// File: rtl/bank_queue_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : bank_queue_monitor
//  Description : Single-bank queue manager. Counts customers from two
//                asynchronous photo sensors (back = join, front = leave),
//                flags full/empty and reports an estimated wait time.
//                Optional feature macro: SBQM_REJECT_FLAG_EN adds a one-cycle
//                'rejected' pulse whenever a lone event is discarded.
//  Ports       : clk           in   system clock, rising edge
//                reset         in   asynchronous, active-low reset
//                backphoto     in   back sensor level (rising edge = join)
//                forwardphoto  in   front sensor level (rising edge = leave)
//                Tcount        in   [1:0]   active tellers
//                Pcount        out  [N-1:0] customers in line (registered)
//                Wtime         out  [N+1:0] estimated wait (combinational)
//                full          out  Pcount == 2**N-1
//                empty         out  Pcount == 0
//                rejected      out  (SBQM_REJECT_FLAG_EN only) discard pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module bank_queue_monitor
    import bank_queue_pkg::*;
#(
    parameter int N = N_DEFAULT
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         backphoto,
    input  logic         forwardphoto,
    input  logic [1:0]   Tcount,
    output logic [N-1:0] Pcount,
    output logic [N+1:0] Wtime,
    output logic         full,
    output logic         empty
`ifdef SBQM_REJECT_FLAG_EN
    ,
    output logic         rejected
`endif
);

    localparam logic [N-1:0] P_MAX = '1;

    // [0] and [1] form the synchronizer, [2] holds the previous synced level
    logic [2:0] back_sync;
    logic [2:0] fwd_sync;

    logic back_evt;
    logic fwd_evt;
    logic enter_only;
    logic leave_only;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            back_sync <= '0;
            fwd_sync  <= '0;
        end else begin
            back_sync <= {back_sync[1:0], backphoto};
            fwd_sync  <= {fwd_sync[1:0],  forwardphoto};
        end
    end

    // An event is a 0->1 transition seen at the second synchronizer stage
    assign back_evt   = back_sync[1] & ~back_sync[2];
    assign fwd_evt    = fwd_sync[1]  & ~fwd_sync[2];

    // Coincident join and leave cancel out, whatever the current count
    assign enter_only = back_evt & ~fwd_evt;
    assign leave_only = fwd_evt  & ~back_evt;

    assign full  = (Pcount == P_MAX);
    assign empty = (Pcount == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Pcount <= '0;
        end else if (enter_only && !full) begin
            Pcount <= Pcount + N'(1);
        end else if (leave_only && !empty) begin
            Pcount <= Pcount - N'(1);
        end
    end

`ifdef SBQM_REJECT_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rejected <= 1'b0;
        end else begin
            rejected <= (enter_only & full) | (leave_only & empty);
        end
    end
`endif

    wait_time_rom #(
        .N      (N)
    ) u_wait_time_rom (
        .Pcount (Pcount),
        .Tcount (Tcount),
        .Wtime  (Wtime)
    );

endmodule : bank_queue_monitor
`default_nettype wire

// File: tb/tb_bank_queue_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bank_queue_monitor
//  Description : Directed self-checking bench for bank_queue_monitor (N=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_queue_monitor;

    localparam int N = 3;

    logic         clk;
    logic         reset;
    logic         backphoto;
    logic         forwardphoto;
    logic [1:0]   Tcount;
    logic [N-1:0] Pcount;
    logic [N+1:0] Wtime;
    logic         full;
    logic         empty;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef SBQM_REJECT_FLAG_EN
    logic rejected;
    int   rej_seen = 0;
    always @(negedge clk) if (rejected === 1'b1) rej_seen++;
`endif

    bank_queue_monitor #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .backphoto    (backphoto),
        .forwardphoto (forwardphoto),
        .Tcount       (Tcount),
        .Pcount       (Pcount),
        .Wtime        (Wtime),
        .full         (full),
        .empty        (empty)
`ifdef SBQM_REJECT_FLAG_EN
        ,
        .rejected     (rejected)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed wait times, indexed [Pcount][Tcount]
    int exp_w [0:7][0:3] = '{
        '{0,  0,  0, 0},
        '{0,  3,  3, 3},
        '{0,  6,  4, 4},
        '{0,  9,  6, 5},
        '{0, 12,  7, 6},
        '{0, 15,  9, 7},
        '{0, 18, 10, 8},
        '{0, 21, 12, 9}
    };

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit back, input bit fwd, input int hi);
        @(negedge clk);
        backphoto    = back;
        forwardphoto = fwd;
        repeat (hi) @(negedge clk);
        backphoto    = 1'b0;
        forwardphoto = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input int p);
        check({tag, " Pcount"}, int'(Pcount), p);
        check({tag, " full"},   int'(full),   (p == 7) ? 1 : 0);
        check({tag, " empty"},  int'(empty),  (p == 0) ? 1 : 0);
    endtask

    initial begin
        reset        = 1'b0;
        backphoto    = 1'b0;
        forwardphoto = 1'b0;
        Tcount       = 2'd1;

        // Reset held while sensors toggle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            backphoto    = ~backphoto;
            forwardphoto = (i % 3 == 0);
        end
        @(negedge clk);
        check_state("reset", 0);
        check("reset Wtime", int'(Wtime), 0);
        backphoto    = 1'b0;
        forwardphoto = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_state("post-release", 0);
        check("post-release Wtime", int'(Wtime), 0);
`ifdef SBQM_REJECT_FLAG_EN
        check("reset rejected", rej_seen, 0);
`endif

        // Count up with one teller, 8th pulse hits a full queue
        for (int i = 1; i <= 8; i++) begin
            pulse(1'b1, 1'b0, 4);
            check_state($sformatf("up%0d", i), (i > 7) ? 7 : i);
            check($sformatf("up%0d Wtime", i), int'(Wtime), 3 * ((i > 7) ? 7 : i));
`ifdef SBQM_REJECT_FLAG_EN
            check($sformatf("up%0d rejected", i), rej_seen, (i > 7) ? 1 : 0);
`endif
        end

        // Lookup sweep while counting down, then one underflow attempt
        for (int p = 7; p >= 0; p--) begin
            for (int t = 0; t < 4; t++) begin
                Tcount = 2'(t);
                #1;
                check($sformatf("lut P%0d T%0d", p, t), int'(Wtime), exp_w[p][t]);
            end
            Tcount = 2'd1;
            pulse(1'b0, 1'b1, 4);
            check_state($sformatf("down from %0d", p), (p > 0) ? p - 1 : 0);
        end
        check("underflow Wtime", int'(Wtime), 0);
`ifdef SBQM_REJECT_FLAG_EN
        check("underflow rejected", rej_seen, 2);
`endif

        // Simultaneous events at 0, 3 and 7 leave the count alone
        pulse(1'b1, 1'b1, 4);
        check_state("both@0", 0);
        repeat (3) pulse(1'b1, 1'b0, 4);
        pulse(1'b1, 1'b1, 4);
        check_state("both@3", 3);
        repeat (4) pulse(1'b1, 1'b0, 4);
        pulse(1'b1, 1'b1, 4);
        check_state("both@7", 7);
`ifdef SBQM_REJECT_FLAG_EN
        check("both rejected", rej_seen, 2);
`endif

        // Exact latency and a long level counted once
        pulse(1'b0, 1'b1, 4);
        check_state("to6", 6);
        @(negedge clk);
        backphoto = 1'b1;
        @(posedge clk); #1;
        check("lat edge k", int'(Pcount), 6);
        @(posedge clk); #1;
        check("lat edge k+1", int'(Pcount), 6);
        @(posedge clk); #1;
        check("lat edge k+2", int'(Pcount), 7);
        repeat (17) @(negedge clk);
        backphoto = 1'b0;
        repeat (4) @(negedge clk);
        check_state("long level", 7);

        // Asynchronous reset between clock edges at Pcount=5
        repeat (2) pulse(1'b0, 1'b1, 4);
        check_state("at5", 5);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async Pcount", int'(Pcount), 0);
        check("async empty", int'(empty), 1);
        check("async Wtime", int'(Wtime), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_state("after async", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_bank_queue_monitor
`default_nettype wire
